// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and constants for the round-robin GCD sequencer
// Purpose: FSM state enum, subtractor-select encodings and default operand width.
// Ports:   none (package).
package gcd_pkg;

  localparam int GCD_W = 16;

  // Subtractor operand selects as seen by the shared datapath.
  localparam logic SEL1_A_MINUS_B = 1'b0;
  localparam logic SEL2_A_MINUS_B = 1'b1;
  localparam logic SEL1_B_MINUS_A = 1'b1;
  localparam logic SEL2_B_MINUS_A = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CMP    = 3'd3,
    SUB_A  = 3'd4,
    SUB_B  = 3'd5,
    DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/gcd_rr_arb.sv
// rtl/gcd_rr_arb.sv - combinational round-robin winner search
// Purpose: picks the first set request at or above ptr_i, wrapping past NREQ-1.
// Ports:   req_i       request vector
//          ptr_i       search start index
//          winner_o    one-hot winner (zero when nothing requests)
//          idx_o       encoded winner index
//          any_req_o   at least one request is set
module gcd_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         winner_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_req_o
);

  localparam int IDXW = $clog2(NREQ);

  always_comb begin
    logic            found;
    int              k;
    logic [IDXW-1:0] kk;
    winner_o  = '0;
    idx_o     = '0;
    any_req_o = |req_i;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      // Modular walk from the pointer; NREQ need not be a power of two.
      k = int'(ptr_i) + i;
      if (k >= NREQ) k = k - NREQ;
      kk = IDXW'(k);
      if (!found && req_i[kk]) begin
        found        = 1'b1;
        winner_o[kk] = 1'b1;
        idx_o        = kk;
      end
    end
  end

endmodule

// File: rtl/gcd_rr_sched.sv
// rtl/gcd_rr_sched.sv - round-robin job sequencer driving a shared subtractive GCD datapath
// Purpose: accepts one operand pair at a time from NREQ requesters, steps the
//          datapath through load/compare/subtract and reports the tagged result.
// Config:  GCD_TIMEOUT_EN adds a per-job subtraction limit of MAX_ITER.
// Ports:   clk, rst                 clock, async active-high reset
//          req, req_a, req_b        per-requester request level and operand slices
//          gnt                      one-hot, one-cycle acceptance pulse
//          data_in, ldA, ldB,
//          sel1, sel2, sel_in       datapath controls
//          gt, lt, eq, a_val        datapath comparator flags and A register
//          busy, done, done_id,
//          result, err              job status and tagged result
module gcd_rr_sched
  import gcd_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int W        = GCD_W,
  parameter int MAX_ITER = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic [NREQ-1:0]         gnt,
  output logic [W-1:0]            data_in,
  output logic                    ldA,
  output logic                    ldB,
  output logic                    sel1,
  output logic                    sel2,
  output logic                    sel_in,
  input  logic                    gt,
  input  logic                    lt,
  input  logic                    eq,
  input  logic [W-1:0]            a_val,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [W-1:0]            result,
  output logic                    err
);

  localparam int IDXW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] win_q, win_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    result_q, result_d;
  logic [IDXW-1:0] done_id_q, done_id_d;

  logic [NREQ-1:0] arb_winner;
  logic [IDXW-1:0] arb_idx;
  logic            arb_any;
  logic [W-1:0]    cap_a;
  logic [W-1:0]    cap_b;
  logic [IDXW-1:0] ptr_next;

`ifdef GCD_TIMEOUT_EN
  localparam int CNTW = $clog2(MAX_ITER + 1);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  gcd_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .winner_o  (arb_winner),
    .idx_o     (arb_idx),
    .any_req_o (arb_any)
  );

  assign cap_a    = req_a[arb_idx*W +: W];
  assign cap_b    = req_b[arb_idx*W +: W];
  assign ptr_next = (arb_idx == IDXW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      gnt_q     <= '0;
      result_q  <= '0;
      done_id_q <= '0;
`ifdef GCD_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      gnt_q     <= gnt_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
`ifdef GCD_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    gnt_d     = '0;
    result_d  = result_q;
    done_id_d = done_id_q;
`ifdef GCD_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    data_in   = '0;
    ldA       = 1'b0;
    ldB       = 1'b0;
    sel1      = 1'b0;
    sel2      = 1'b0;
    sel_in    = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          op_a_d = cap_a;
          op_b_d = cap_b;
          win_d  = arb_idx;
          gnt_d  = arb_winner;
          ptr_d  = ptr_next;
`ifdef GCD_TIMEOUT_EN
          cnt_d  = '0;
`endif
          // gcd(x,0) = x; skipping the datapath also keeps the
          // subtract loop from spinning forever on a zero operand.
          if (cap_a == '0 || cap_b == '0) begin
            state_d   = DONE;
            result_d  = cap_a | cap_b;
            done_id_d = arb_idx;
          end else begin
            state_d = LOAD_A;
          end
        end
      end

      LOAD_A: begin
        data_in = op_a_q;
        sel_in  = 1'b1;
        ldA     = 1'b1;
        state_d = LOAD_B;
      end

      LOAD_B: begin
        data_in = op_b_q;
        sel_in  = 1'b1;
        ldB     = 1'b1;
        state_d = CMP;
      end

      CMP: begin
        // Result is registered on the way into DONE so it holds afterwards.
        state_d   = DONE;
        done_id_d = win_q;
        result_d  = a_val;
        if (eq) begin
          state_d = DONE;
`ifdef GCD_TIMEOUT_EN
        end else if (cnt_q == CNTW'(MAX_ITER)) begin
          result_d = '0;
          err_d    = 1'b1;
`endif
        end else if (gt) begin
          state_d = SUB_A;
        end else if (lt) begin
          state_d = SUB_B;
        end else begin
          // No comparator flag: datapath is broken, give up on the job.
`ifdef GCD_TIMEOUT_EN
          err_d = 1'b1;
`endif
        end
      end

      SUB_A: begin
        sel1    = SEL1_A_MINUS_B;
        sel2    = SEL2_A_MINUS_B;
        ldA     = 1'b1;
        state_d = CMP;
`ifdef GCD_TIMEOUT_EN
        cnt_d   = cnt_q + 1'b1;
`endif
      end

      SUB_B: begin
        sel1    = SEL1_B_MINUS_A;
        sel2    = SEL2_B_MINUS_A;
        ldB     = 1'b1;
        state_d = CMP;
`ifdef GCD_TIMEOUT_EN
        cnt_d   = cnt_q + 1'b1;
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = done_id_q;
  assign result  = result_q;
`ifdef GCD_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_rr_sched.sv
// tb/tb_gcd_rr_sched.sv - directed self-checking bench for gcd_rr_sched with a behavioural datapath
module tb_gcd_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      data_in;
  logic              ldA, ldB, sel1, sel2, sel_in;
  logic              gt, lt, eq;
  logic [W-1:0]      a_val;
  logic              busy, done, err;
  logic [1:0]        done_id;
  logic [W-1:0]      result;

  gcd_rr_sched #(.NREQ(NREQ), .W(W), .MAX_ITER(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .data_in(data_in), .ldA(ldA), .ldB(ldB),
    .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .gt(gt), .lt(lt), .eq(eq), .a_val(a_val),
    .busy(busy), .done(done), .done_id(done_id), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural GCD datapath: A/B registers, shared subtractor, comparator.
  logic [W-1:0] dp_a, dp_b, dp_sub;
  assign dp_sub = (!sel1 && sel2) ? dp_a - dp_b : dp_b - dp_a;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a <= '0;
      dp_b <= '0;
    end else begin
      if (ldA) dp_a <= sel_in ? data_in : dp_sub;
      if (ldB) dp_b <= sel_in ? data_in : dp_sub;
    end
  end
  assign gt    = dp_a > dp_b;
  assign lt    = dp_a < dp_b;
  assign eq    = dp_a == dp_b;
  assign a_val = dp_a;

  // Event monitor, sampled mid-cycle.
  int         cyc = 0, gnt_cyc = 0, done_cyc = 0, done_cnt = 0, subs = 0, loads = 0;
  logic [1:0] d_id;
  logic [W-1:0] d_res;
  logic       d_err;
  logic [3:0] gnt_log [$];
  logic [1:0] id_log [$];
  logic [W-1:0] res_log [$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (|gnt) begin
      gnt_cyc = cyc;
      gnt_log.push_back(gnt);
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt = done_cnt + 1;
      d_id  = done_id;
      d_res = result;
      d_err = err;
      id_log.push_back(done_id);
      res_log.push_back(result);
    end
    if ((ldA || ldB) && !sel_in) subs = subs + 1;
    if (ldA || ldB) loads = loads + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_job(input string nm, input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int e_res, input int e_lat, input int e_subs, input int e_loads,
                        input int e_err);
    int n;
    int base_done, base_subs, base_loads;
    @(posedge clk); #1;
    base_done  = done_cnt;
    base_subs  = subs;
    base_loads = loads;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req[idx] = 1'b1;
    n = 0;
    while (gnt == '0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " gnt"}, 32'(gnt), 32'(1 << idx));
    check({nm, " busy"}, 32'(busy), 32'd1);
    req[idx] = 1'b0;
    n = 0;
    while (done_cnt == base_done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " done_count"}, 32'(done_cnt - base_done), 32'd1);
    check({nm, " latency"}, 32'(done_cyc - gnt_cyc), 32'(e_lat));
    check({nm, " result"}, 32'(d_res), 32'(e_res));
    check({nm, " done_id"}, 32'(d_id), 32'(idx));
    check({nm, " err"}, 32'(d_err), 32'(e_err));
    check({nm, " subs"}, 32'(subs - base_subs), 32'(e_subs));
    check({nm, " loads"}, 32'(loads - base_loads), 32'(e_loads));
  endtask

  initial begin
    int n;
    int base_g, base_d, base_done;
    logic [3:0]   exp_g [5];
    logic [W-1:0] exp_r [4];

    rst   = 1'b1;
    req   = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ctrl", 32'({ldA, ldB, sel1, sel2, sel_in}), 32'd0);
    check("reset data_in", 32'(data_in), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset done_id", 32'(done_id), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;

    // 143,78 -> 65,78 -> 65,13 -> 52 -> 39 -> 26 -> 13 : six subtractions
    do_job("j143_78", 0, 16'd143, 16'd78, 13, 15, 6, 8, 0);
    do_job("j7_7",    2, 16'd7,   16'd7,  7,  3,  0, 2, 0);
    do_job("j0_0",    1, 16'd0,   16'd0,  0,  0,  0, 0, 0);
    do_job("j0_45",   1, 16'd0,   16'd45, 45, 0,  0, 0, 0);

    // Reset in the middle of a long subtract run on requester 2.
    @(posedge clk); #1;
    base_done = done_cnt;
    req_a[2*W +: W] = 16'd300;
    req_b[2*W +: W] = 16'd1;
    req[2] = 1'b1;
    n = 0;
    while (!(ldA && !sel_in) && n < 20) begin
      @(posedge clk); #1;
      if (|gnt) req[2] = 1'b0;
      n++;
    end
    req = '0;
    check("rst_mid in SUB_A", 32'(ldA && !sel_in), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid gnt/busy/done", 32'({|gnt, busy, done}), 32'd0);
    check("rst_mid ctrl", 32'({ldA, ldB, sel1, sel2, sel_in}), 32'd0);
    check("rst_mid data_in", 32'(data_in), 32'd0);
    check("rst_mid result", 32'(result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_mid no done", 32'(done_cnt - base_done), 32'd0);

    // All four request continuously; pointer restarts at 0 after the reset.
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{16'd4, 16'd3, 16'd5, 16'd7};
    req_a = {16'd21, 16'd5, 16'd9, 16'd12};
    req_b = {16'd14, 16'd5, 16'd6, 16'd8};
    base_g = gnt_log.size();
    base_d = id_log.size();
    req = 4'b1111;
    n = 0;
    while (gnt_log.size() - base_g < 5 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    req = '0;
    n = 0;
    while (id_log.size() - base_d < 5 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("rr grant count", 32'(gnt_log.size() - base_g), 32'd5);
    check("rr done count", 32'(id_log.size() - base_d), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (gnt_log.size() > base_g + k && id_log.size() > base_d + k) begin
        check($sformatf("rr gnt[%0d]", k), 32'(gnt_log[base_g + k]), 32'(exp_g[k]));
        check($sformatf("rr done_id[%0d]", k), 32'(id_log[base_d + k]), 32'(k % 4));
        check($sformatf("rr result[%0d]", k), 32'(res_log[base_d + k]), 32'(exp_r[k % 4]));
      end
    end
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rr idle", 32'(busy), 32'd0);

`ifdef GCD_TIMEOUT_EN
    do_job("timeout", 0, 16'd1, 16'd65535, 0, 35, 16, 18, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
